alu_ctl_muldiv: RTL and testbench
=================================

Name: alu_ctl_muldiv

Overview:
Next-generation ALU control for the MIPS EX stage. It keeps the full R-type and immediate ALU-op decode and adds a multi-cycle multiply/divide engine with HI/LO registers. It also drives a stall request to the hazard unit. It sits beside the ALU, and its HI/LO read path feeds the EX result mux.

Parameters:
- NB_DATA, 32, operand / HI / LO width (even, ≥4)
- BITS_FUNCT, 6, funct and opcode field width
- BITS_ALU_CTL, 2, width of i_alu_op from main control
- NB_ALU_OP, 4, width of o_alu_op
- NB_CNT, 6, iteration counter width (≥ clog2(NB_DATA)+1)

Ports:
- i_clk  in  1  clock, rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_valid  in  1  EX-stage instruction is valid and not bubbled
- i_flush  in  1  abort in-flight mul/div; HI/LO untouched
- i_alu_op  in  BITS_ALU_CTL  class from main control (00 add, 01 sub, 10 R-type, 11 immediate)
- i_funct  in  BITS_FUNCT  instr[5:0]
- i_opcode  in  BITS_FUNCT  instr[31:26]
- i_rs_data  in  NB_DATA  rs operand (dividend / multiplicand / MTHI-MTLO source)
- i_rt_data  in  NB_DATA  rt operand (divisor / multiplier)
- o_alu_op  out  NB_ALU_OP  ALU operation code
- o_shamt  out  1  1 for SLL/SRL/SRA (shift amount from shamt field)
- o_hilo_sel  out  1  1 selects o_hilo_data as the EX result (MFHI/MFLO)
- o_hilo_data  out  NB_DATA  HI for MFHI, LO for MFLO
- o_busy  out  1  engine not idle
- o_stall  out  1  hold IF/ID/EX this cycle
- o_div_by_zero  out  1  one-cycle pulse

Behaviour:
- Reset (async, low): state IDLE, HI=0, LO=0, counter=0, o_busy=0, o_div_by_zero=0. Combinational outputs follow inputs.
- Decode (combinational) for classes 00, 01, 10, 11:
  - Class 00 → 0010; class 01 → 0110.
  - Class 10 (by funct): ADD/ADDU 0010, SUB/SUBU 0110, AND 0000, OR 0001, NOR 1100, XOR 1101, SLT 0111, SLTU 1000, SLL/SLLV 0011, SRL/SRLV 0100, SRA/SRAV 0101.
  - Class 11 (by opcode): ADDI/ADDIU 0010, SLTI 0111, SLTIU 1000, ANDI 0000, ORI 0001, XORI 1101.
  - MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO → 0010.
  - Unknown funct/opcode → 1111 (NOP code).
- o_shamt=1 only when class=10 and funct is SLL, SRL or SRA; otherwise 0.
- Function codes: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
- o_hilo_sel=1 when class=10 and funct is MFHI/MFLO; o_hilo_data is the registered HI or LO.
- Issue: a mul/div is accepted at edge T when i_valid, class=10, funct ∈ {MULT,MULTU,DIV,DIVU}, state IDLE, and !i_flush. Operands are latched at that edge.
- Signed ops: the engine iterates on absolute values.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Most-negative / -1: wraps per two's complement, no trap.
- FSM:
  - IDLE → CALC on accept (counter=0).
  - CALC: one radix-2 step per cycle; shift-add for multiply, restoring for divide. After NB_DATA cycles (counter==NB_DATA-1) → FIX.
  - FIX: sign correction; HI/LO written at the FIX edge; → IDLE.
  - Multiply: HI={upper}, LO={lower} of the 2·NB_DATA-bit product. Divide: LO=quotient, HI=remainder.
  - Latency: HI/LO are updated at edge T+NB_DATA+1; o_busy=1 for cycles T+1..T+NB_DATA+1.
- Divide by zero: IDLE → FIX directly. Result is HI=dividend (raw rs), LO=all ones. o_div_by_zero=1 during that FIX cycle. HI/LO are written at edge T+1.
- MTHI/MTLO: write rs into HI/LO at the edge when i_valid and state IDLE and !i_flush.
- o_stall = i_valid & o_busy & (funct ∈ {MULT,MULTU,DIV,DIVU,MFHI,MFLO,MTHI,MTLO}) & class=10. Stalled instructions are neither accepted nor written.
- Flush: i_flush=1 in any state forces IDLE at the next edge. HI/LO keep their pre-operation values and no div_by_zero pulse is produced. Flush and issue in the same cycle → flush wins.
- Reset mid-operation: immediate IDLE; HI=LO=0.

Decomposition:
- Package alu_ctl_pkg holds:
  - funct/opcode localparams (including the new mul/div/HI-LO codes);
  - ALU op codes (ADD 0010, SUB 0110, …, NOP 1111);
  - the FSM state encoding (IDLE, CALC, FIX).
- One sub-module, muldiv_core: iteration datapath, counter and sign fix-up, with start/signed/is_div in and done/hi/lo out.
- The top level holds the decode, HI/LO registers, stall and flush logic.

Test Plan:
- Decode sweep: every listed funct under class 10 and every opcode under class 11 → the codes above; funct 111111 → 1111. SLL → o_shamt=1; SLLV → o_shamt=0.
- MULT rs=0xFFFFFFFD (-3), rt=7 → after 33 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB; then MFHI → o_hilo_data=0xFFFFFFFF with o_hilo_sel=1.
- DIVU 100/7 → LO=0x0000000E, HI=0x00000002. DIV 0xFFFFFFF9 (-7)/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 5/0 → o_div_by_zero=1 for exactly one cycle; HI=5, LO=0xFFFFFFFF at T+1; o_busy=1 for 1 cycle.
- MFLO issued 3 cycles after MULT → o_stall=1 until cycle T+NB_DATA+2, then LO reads the new product. MTHI 0x1234 while busy → stalled, HI unchanged until it is accepted after IDLE.
- Assert i_flush mid-CALC (HI=0xAAAA preloaded via MTHI) → IDLE next cycle, HI stays 0xAAAA. Assert i_reset_n=0 mid-CALC → o_busy=0 immediately, HI=LO=0.

Source files
------------

// File: rtl/alu_ctl_pkg.sv
// Shared decode constants, ALU operation codes and mul/div FSM encoding for the
// EX-stage ALU control block.
package alu_ctl_pkg;

    // R-type funct codes
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    // Immediate opcodes
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_SLTIU = 6'b001011;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_XORI  = 6'b001110;

    // Class from main control
    localparam logic [1:0] CLS_ADD   = 2'b00;
    localparam logic [1:0] CLS_SUB   = 2'b01;
    localparam logic [1:0] CLS_RTYPE = 2'b10;
    localparam logic [1:0] CLS_IMM   = 2'b11;

    // ALU operation codes
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b1101;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/alu_ctl_muldiv_if.sv
// EX-stage bundle between the pipeline and the ALU control / mul-div block.
interface alu_ctl_muldiv_if #(
    parameter int NB_DATA      = 32,
    parameter int BITS_FUNCT   = 6,
    parameter int BITS_ALU_CTL = 2,
    parameter int NB_ALU_OP    = 4
);
    logic                    i_valid;
    logic                    i_flush;
    logic [BITS_ALU_CTL-1:0] i_alu_op;
    logic [BITS_FUNCT-1:0]   i_funct;
    logic [BITS_FUNCT-1:0]   i_opcode;
    logic [NB_DATA-1:0]      i_rs_data;
    logic [NB_DATA-1:0]      i_rt_data;
    logic [NB_ALU_OP-1:0]    o_alu_op;
    logic                    o_shamt;
    logic                    o_hilo_sel;
    logic [NB_DATA-1:0]      o_hilo_data;
    logic                    o_busy;
    logic                    o_stall;
    logic                    o_div_by_zero;

    modport master (
        output i_valid, i_flush, i_alu_op, i_funct, i_opcode, i_rs_data, i_rt_data,
        input  o_alu_op, o_shamt, o_hilo_sel, o_hilo_data, o_busy, o_stall, o_div_by_zero
    );

    modport slave (
        input  i_valid, i_flush, i_alu_op, i_funct, i_opcode, i_rs_data, i_rt_data,
        output o_alu_op, o_shamt, o_hilo_sel, o_hilo_data, o_busy, o_stall, o_div_by_zero
    );
endinterface

// File: rtl/alu_ctl_muldiv_core.sv
// Radix-2 multiply/divide engine: shift-add multiply, restoring divide, both on
// operand magnitudes with a final sign fix-up cycle.
module muldiv_core
    import alu_ctl_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_CNT  = 6
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_signed,
    input  logic               i_is_div,
    input  logic [NB_DATA-1:0] i_a,
    input  logic [NB_DATA-1:0] i_b,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_div_by_zero,
    output logic [NB_DATA-1:0] o_hi,
    output logic [NB_DATA-1:0] o_lo
);
    localparam int NB2 = 2 * NB_DATA;

    md_state_e          state_q, state_d;
    logic [NB_CNT-1:0]  cnt_q, cnt_d;
    logic               dbz_q, dbz_d;
    logic [NB2-1:0]     acc_q, acc_d;
    logic [NB_DATA-1:0] opb_q, opb_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               neg_rem_q, neg_rem_d;

    logic               sign_a, sign_b, b_zero, accept;
    logic [NB_DATA-1:0] abs_a, abs_b;
    logic [NB_DATA:0]   mul_sum, div_sh, div_diff;
    logic               div_ge;
    logic [NB2-1:0]     prod_fix;
    logic [NB_DATA-1:0] quo_fix, rem_fix;

    assign sign_a = i_signed & i_a[NB_DATA-1];
    assign sign_b = i_signed & i_b[NB_DATA-1];
    assign abs_a  = sign_a ? -i_a : i_a;
    assign abs_b  = sign_b ? -i_b : i_b;
    assign b_zero = (i_b == '0);
    assign accept = (state_q == ST_IDLE) & i_start & ~i_abort;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    always_ff @(posedge i_clk) begin
        acc_q     <= acc_d;
        opb_q     <= opb_d;
        is_div_q  <= is_div_d;
        neg_q     <= neg_d;
        neg_rem_q <= neg_rem_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (i_start) state_d = (i_is_div && b_zero) ? ST_FIX : ST_CALC;
                ST_CALC: if (cnt_q == NB_CNT'(NB_DATA - 1)) state_d = ST_FIX;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Accumulator: upper half is partial product / remainder, lower half holds
    // the multiplier or dividend bits still to be consumed.
    always_comb begin
        cnt_d     = cnt_q;
        dbz_d     = dbz_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        mul_sum   = {1'b0, acc_q[NB2-1:NB_DATA]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_sh    = acc_q[NB2-1:NB_DATA-1];
        div_ge    = (div_sh >= {1'b0, opb_q});
        div_diff  = div_sh - {1'b0, opb_q};
        if (accept) begin
            cnt_d     = '0;
            dbz_d     = i_is_div & b_zero;
            is_div_d  = i_is_div;
            neg_d     = sign_a ^ sign_b;
            neg_rem_d = sign_a;
            if (i_is_div && b_zero) begin
                acc_d = {{NB_DATA{1'b0}}, i_a};
            end else if (i_is_div) begin
                acc_d = {{NB_DATA{1'b0}}, abs_a};
                opb_d = abs_b;
            end else begin
                acc_d = {{NB_DATA{1'b0}}, abs_b};
                opb_d = abs_a;
            end
        end else if (state_q == ST_CALC) begin
            cnt_d = cnt_q + NB_CNT'(1);
            if (is_div_q)
                acc_d = {(div_ge ? div_diff[NB_DATA-1:0] : div_sh[NB_DATA-1:0]),
                         acc_q[NB_DATA-2:0], div_ge};
            else
                acc_d = {mul_sum, acc_q[NB_DATA-1:1]};
        end
    end

    always_comb begin
        prod_fix      = neg_q ? -acc_q : acc_q;
        quo_fix       = neg_q ? -acc_q[NB_DATA-1:0] : acc_q[NB_DATA-1:0];
        rem_fix       = neg_rem_q ? -acc_q[NB2-1:NB_DATA] : acc_q[NB2-1:NB_DATA];
        o_busy        = (state_q != ST_IDLE);
        o_done        = (state_q == ST_FIX) & ~i_abort;
        o_div_by_zero = o_done & dbz_q;
        if (dbz_q) begin
            o_hi = acc_q[NB_DATA-1:0];
            o_lo = '1;
        end else if (is_div_q) begin
            o_hi = rem_fix;
            o_lo = quo_fix;
        end else begin
            o_hi = prod_fix[NB2-1:NB_DATA];
            o_lo = prod_fix[NB_DATA-1:0];
        end
    end
endmodule

// File: rtl/alu_ctl_muldiv.sv
// EX-stage ALU control: ALU-op decode, HI/LO registers with MFHI/MFLO read path,
// mul/div issue, hazard stall request and flush handling.
module alu_ctl_muldiv
    import alu_ctl_pkg::*;
#(
    parameter int NB_DATA      = 32,
    parameter int BITS_FUNCT   = 6,
    parameter int BITS_ALU_CTL = 2,
    parameter int NB_ALU_OP    = 4,
    parameter int NB_CNT       = 6
) (
    input logic             i_clk,
    input logic             i_reset_n,
    alu_ctl_muldiv_if.slave bus
);
    logic [BITS_FUNCT-1:0]   funct, opcode;
    logic [BITS_ALU_CTL-1:0] cls;
    logic                    rtype, is_md, is_hilo, idle;
    logic                    accept, mthi_wr, mtlo_wr;
    logic [3:0]              alu_op_c;
    logic                    shamt_c;
    logic [NB_DATA-1:0]      hi_q, hi_d, lo_q, lo_d;
    logic                    core_busy, core_done, core_dbz;
    logic [NB_DATA-1:0]      core_hi, core_lo;

    assign funct   = bus.i_funct;
    assign opcode  = bus.i_opcode;
    assign cls     = bus.i_alu_op;
    assign rtype   = (cls == CLS_RTYPE);
    assign is_md   = rtype & (funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
    assign is_hilo = rtype & (funct inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO});
    assign idle    = ~core_busy;
    assign accept  = bus.i_valid & is_md & idle & ~bus.i_flush;
    assign mthi_wr = bus.i_valid & rtype & (funct == F_MTHI) & idle & ~bus.i_flush;
    assign mtlo_wr = bus.i_valid & rtype & (funct == F_MTLO) & idle & ~bus.i_flush;

    always_comb begin
        alu_op_c = OP_NOP;
        shamt_c  = 1'b0;
        case (cls)
            CLS_ADD: alu_op_c = OP_ADD;
            CLS_SUB: alu_op_c = OP_SUB;
            CLS_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU:   alu_op_c = OP_ADD;
                    F_SUB, F_SUBU:   alu_op_c = OP_SUB;
                    F_AND:           alu_op_c = OP_AND;
                    F_OR:            alu_op_c = OP_OR;
                    F_NOR:           alu_op_c = OP_NOR;
                    F_XOR:           alu_op_c = OP_XOR;
                    F_SLT:           alu_op_c = OP_SLT;
                    F_SLTU:          alu_op_c = OP_SLTU;
                    F_SLL: begin     alu_op_c = OP_SLL; shamt_c = 1'b1; end
                    F_SRL: begin     alu_op_c = OP_SRL; shamt_c = 1'b1; end
                    F_SRA: begin     alu_op_c = OP_SRA; shamt_c = 1'b1; end
                    F_SLLV:          alu_op_c = OP_SLL;
                    F_SRLV:          alu_op_c = OP_SRL;
                    F_SRAV:          alu_op_c = OP_SRA;
                    F_MULT, F_MULTU, F_DIV, F_DIVU,
                    F_MFHI, F_MFLO, F_MTHI, F_MTLO: alu_op_c = OP_ADD;
                    default:         alu_op_c = OP_NOP;
                endcase
            end
            default: begin
                case (opcode)
                    OPC_ADDI, OPC_ADDIU: alu_op_c = OP_ADD;
                    OPC_SLTI:            alu_op_c = OP_SLT;
                    OPC_SLTIU:           alu_op_c = OP_SLTU;
                    OPC_ANDI:            alu_op_c = OP_AND;
                    OPC_ORI:             alu_op_c = OP_OR;
                    OPC_XORI:            alu_op_c = OP_XOR;
                    default:             alu_op_c = OP_NOP;
                endcase
            end
        endcase
    end

    // A finishing operation and an MTHI/MTLO can never coincide: moves need idle.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (core_done) begin
            hi_d = core_hi;
            lo_d = core_lo;
        end else begin
            if (mthi_wr) hi_d = bus.i_rs_data;
            if (mtlo_wr) lo_d = bus.i_rs_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    muldiv_core #(
        .NB_DATA (NB_DATA),
        .NB_CNT  (NB_CNT)
    ) u_core (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_start       (accept),
        .i_abort       (bus.i_flush),
        .i_signed      ((funct == F_MULT) || (funct == F_DIV)),
        .i_is_div      ((funct == F_DIV) || (funct == F_DIVU)),
        .i_a           (bus.i_rs_data),
        .i_b           (bus.i_rt_data),
        .o_busy        (core_busy),
        .o_done        (core_done),
        .o_div_by_zero (core_dbz),
        .o_hi          (core_hi),
        .o_lo          (core_lo)
    );

    assign bus.o_alu_op      = NB_ALU_OP'(alu_op_c);
    assign bus.o_shamt       = shamt_c;
    assign bus.o_hilo_sel    = rtype & ((funct == F_MFHI) || (funct == F_MFLO));
    assign bus.o_hilo_data   = (funct == F_MFHI) ? hi_q : lo_q;
    assign bus.o_busy        = core_busy;
    assign bus.o_stall       = bus.i_valid & core_busy & (is_md | is_hilo);
    assign bus.o_div_by_zero = core_dbz;
endmodule

// File: tb/tb_alu_ctl_muldiv.sv
// Directed self-checking bench for alu_ctl_muldiv: decode sweep, mul/div results,
// divide-by-zero, stall timing, flush and mid-operation reset.
module tb_alu_ctl_muldiv;
    import alu_ctl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_ctl_muldiv_if #(.NB_DATA(32), .BITS_FUNCT(6), .BITS_ALU_CTL(2), .NB_ALU_OP(4)) bus ();

    alu_ctl_muldiv #(
        .NB_DATA(32), .BITS_FUNCT(6), .BITS_ALU_CTL(2), .NB_ALU_OP(4), .NB_CNT(6)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    // {funct, alu_op, shamt, hilo_sel}
    localparam logic [11:0] RTAB [25] = '{
        {6'b100000, 4'b0010, 1'b0, 1'b0}, {6'b100001, 4'b0010, 1'b0, 1'b0},
        {6'b100010, 4'b0110, 1'b0, 1'b0}, {6'b100011, 4'b0110, 1'b0, 1'b0},
        {6'b100100, 4'b0000, 1'b0, 1'b0}, {6'b100101, 4'b0001, 1'b0, 1'b0},
        {6'b100111, 4'b1100, 1'b0, 1'b0}, {6'b100110, 4'b1101, 1'b0, 1'b0},
        {6'b101010, 4'b0111, 1'b0, 1'b0}, {6'b101011, 4'b1000, 1'b0, 1'b0},
        {6'b000000, 4'b0011, 1'b1, 1'b0}, {6'b000100, 4'b0011, 1'b0, 1'b0},
        {6'b000010, 4'b0100, 1'b1, 1'b0}, {6'b000110, 4'b0100, 1'b0, 1'b0},
        {6'b000011, 4'b0101, 1'b1, 1'b0}, {6'b000111, 4'b0101, 1'b0, 1'b0},
        {6'b010000, 4'b0010, 1'b0, 1'b1}, {6'b010001, 4'b0010, 1'b0, 1'b0},
        {6'b010010, 4'b0010, 1'b0, 1'b1}, {6'b010011, 4'b0010, 1'b0, 1'b0},
        {6'b011000, 4'b0010, 1'b0, 1'b0}, {6'b011001, 4'b0010, 1'b0, 1'b0},
        {6'b011010, 4'b0010, 1'b0, 1'b0}, {6'b011011, 4'b0010, 1'b0, 1'b0},
        {6'b111111, 4'b1111, 1'b0, 1'b0}
    };

    // {opcode, alu_op}
    localparam logic [9:0] ITAB [8] = '{
        {6'b001000, 4'b0010}, {6'b001001, 4'b0010}, {6'b001010, 4'b0111},
        {6'b001011, 4'b1000}, {6'b001100, 4'b0000}, {6'b001101, 4'b0001},
        {6'b001110, 4'b1101}, {6'b111111, 4'b1111}
    };

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] cls, input logic [5:0] f,
                         input logic [31:0] rs, input logic [31:0] rt);
        bus.i_valid   = v;
        bus.i_alu_op  = cls;
        bus.i_funct   = f;
        bus.i_opcode  = 6'b000000;
        bus.i_rs_data = rs;
        bus.i_rt_data = rt;
    endtask

    task automatic idle_in();
        drive(1'b0, 2'b00, 6'b000000, 32'h0, 32'h0);
    endtask

    task automatic read_hilo(input logic [5:0] f, output logic [31:0] d);
        bus.i_alu_op = CLS_RTYPE;
        bus.i_funct  = f;
        #1;
        d = bus.o_hilo_data;
    endtask

    // Issue one mul/div and count the cycles o_busy stays high (bounded).
    task automatic run_op(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                          output int n);
        drive(1'b1, CLS_RTYPE, f, rs, rt);
        tick();
        idle_in();
        n = 0;
        while (bus.o_busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        tick();
        tick();
        drive(1'b1, CLS_RTYPE, F_MFHI, 32'h0, 32'h0);
        #1;
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
        checks++; if (bus.o_div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", bus.o_div_by_zero); end
        checks++; if (bus.o_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.o_stall); end
        bus.i_valid = 1'b0;
        read_hilo(F_MFHI, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=00000000", d); end
        read_hilo(F_MFLO, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=00000000", d); end
        rst_n = 1'b1;
        idle_in();
        tick();
    endtask

    task automatic test_decode();
        drive(1'b0, CLS_ADD, 6'b101010, 32'h0, 32'h0);
        #1;
        checks++; if (bus.o_alu_op !== 4'b0010) begin failures++; $display("FAIL dec_cls00 got=%b exp=0010", bus.o_alu_op); end
        bus.i_alu_op = CLS_SUB;
        #1;
        checks++; if (bus.o_alu_op !== 4'b0110) begin failures++; $display("FAIL dec_cls01 got=%b exp=0110", bus.o_alu_op); end
        for (int i = 0; i < 25; i++) begin
            logic [11:0] e;
            e = RTAB[i];
            drive(1'b0, CLS_RTYPE, e[11:6], 32'h0, 32'h0);
            #1;
            checks++;
            if (bus.o_alu_op !== e[5:2] || bus.o_shamt !== e[1] || bus.o_hilo_sel !== e[0]) begin
                failures++;
                $display("FAIL dec_rtype funct=%b got op=%b sh=%b sel=%b exp op=%b sh=%b sel=%b",
                         e[11:6], bus.o_alu_op, bus.o_shamt, bus.o_hilo_sel, e[5:2], e[1], e[0]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            logic [9:0] e;
            e = ITAB[i];
            drive(1'b0, CLS_IMM, 6'b000000, 32'h0, 32'h0);
            bus.i_opcode = e[9:4];
            #1;
            checks++;
            if (bus.o_alu_op !== e[3:0] || bus.o_shamt !== 1'b0) begin
                failures++;
                $display("FAIL dec_imm opcode=%b got op=%b sh=%b exp op=%b sh=0",
                         e[9:4], bus.o_alu_op, bus.o_shamt, e[3:0]);
            end
        end
        idle_in();
    endtask

    task automatic test_mult();
        int n;
        logic [31:0] d;
        run_op(F_MULT, 32'hFFFFFFFD, 32'h7, n);
        checks++; if (n !== 33) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=33", n); end
        drive(1'b1, CLS_RTYPE, F_MFHI, 32'h0, 32'h0);
        #1;
        checks++; if (bus.o_hilo_sel !== 1'b1) begin failures++; $display("FAIL mfhi_sel got=%b exp=1", bus.o_hilo_sel); end
        checks++; if (bus.o_hilo_data !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", bus.o_hilo_data); end
        idle_in();
        read_hilo(F_MFLO, d);
        checks++; if (d !== 32'hFFFFFFEB) begin failures++; $display("FAIL mult_lo got=%h exp=ffffffeb", d); end
        run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
        read_hilo(F_MFHI, d);
        checks++; if (d !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_hi got=%h exp=fffffffe", d); end
        read_hilo(F_MFLO, d);
        checks++; if (d !== 32'h00000001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", d); end
    endtask

    task automatic test_div();
        int n;
        logic [31:0] d;
        run_op(F_DIVU, 32'd100, 32'd7, n);
        checks++; if (n !== 33) begin failures++; $display("FAIL divu_busy_cycles got=%0d exp=33", n); end
        read_hilo(F_MFLO, d);
        checks++; if (d !== 32'h0000000E) begin failures++; $display("FAIL divu_lo got=%h exp=0000000e", d); end
        read_hilo(F_MFHI, d);
        checks++; if (d !== 32'h00000002) begin failures++; $display("FAIL divu_hi got=%h exp=00000002", d); end
        run_op(F_DIV, 32'hFFFFFFF9, 32'd2, n);
        read_hilo(F_MFLO, d);
        checks++; if (d !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_neg_lo got=%h exp=fffffffd", d); end
        read_hilo(F_MFHI, d);
        checks++; if (d !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_neg_hi got=%h exp=ffffffff", d); end
        run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, n);
        read_hilo(F_MFLO, d);
        checks++; if (d !== 32'h80000000) begin failures++; $display("FAIL div_wrap_lo got=%h exp=80000000", d); end
        read_hilo(F_MFHI, d);
        checks++; if (d !== 32'h00000000) begin failures++; $display("FAIL div_wrap_hi got=%h exp=00000000", d); end
    endtask

    task automatic test_div_by_zero();
        logic [31:0] d;
        drive(1'b1, CLS_RTYPE, F_DIV, 32'd5, 32'd0);
        tick();
        idle_in();
        #1;
        checks++; if (bus.o_div_by_zero !== 1'b1) begin failures++; $display("FAIL dbz_pulse got=%b exp=1", bus.o_div_by_zero); end
        checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL dbz_busy got=%b exp=1", bus.o_busy); end
        tick();
        checks++; if (bus.o_div_by_zero !== 1'b0) begin failures++; $display("FAIL dbz_pulse_end got=%b exp=0", bus.o_div_by_zero); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL dbz_busy_end got=%b exp=0", bus.o_busy); end
        read_hilo(F_MFHI, d);
        checks++; if (d !== 32'd5) begin failures++; $display("FAIL dbz_hi got=%h exp=00000005", d); end
        read_hilo(F_MFLO, d);
        checks++; if (d !== 32'hFFFFFFFF) begin failures++; $display("FAIL dbz_lo got=%h exp=ffffffff", d); end
        idle_in();
    endtask

    task automatic test_stall_mflo();
        int n;
        drive(1'b1, CLS_RTYPE, F_MULT, 32'd3, 32'd5);
        tick();
        idle_in();
        tick();
        tick();
        drive(1'b1, CLS_RTYPE, F_MFLO, 32'h0, 32'h0);
        #1;
        n = 0;
        while (bus.o_stall && n < 100) begin
            n++;
            tick();
        end
        checks++; if (n !== 31) begin failures++; $display("FAIL mflo_stall_cycles got=%0d exp=31", n); end
        checks++; if (bus.o_hilo_data !== 32'd15) begin failures++; $display("FAIL mflo_after_stall got=%h exp=0000000f", bus.o_hilo_data); end
        idle_in();
    endtask

    task automatic test_mthi_stall();
        int n;
        logic [31:0] d;
        drive(1'b1, CLS_RTYPE, F_MULT, 32'h00010000, 32'h00030000);
        tick();
        drive(1'b1, CLS_RTYPE, F_MTHI, 32'h00001234, 32'h0);
        #1;
        checks++; if (bus.o_stall !== 1'b1) begin failures++; $display("FAIL mthi_stall got=%b exp=1", bus.o_stall); end
        n = 0;
        while (bus.o_stall && n < 100) begin
            n++;
            tick();
        end
        checks++; if (n !== 33) begin failures++; $display("FAIL mthi_stall_cycles got=%0d exp=33", n); end
        bus.i_funct = F_MFHI;
        #1;
        checks++; if (bus.o_hilo_data !== 32'h3) begin failures++; $display("FAIL mthi_hi_before got=%h exp=00000003", bus.o_hilo_data); end
        bus.i_funct = F_MTHI;
        #1;
        tick();
        idle_in();
        read_hilo(F_MFHI, d);
        checks++; if (d !== 32'h00001234) begin failures++; $display("FAIL mthi_hi_after got=%h exp=00001234", d); end
        read_hilo(F_MFLO, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL mthi_lo_kept got=%h exp=00000000", d); end
    endtask

    task automatic test_flush();
        logic [31:0] d;
        drive(1'b1, CLS_RTYPE, F_MTHI, 32'h0000AAAA, 32'h0);
        tick();
        drive(1'b1, CLS_RTYPE, F_MTLO, 32'h00005555, 32'h0);
        tick();
        drive(1'b1, CLS_RTYPE, F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        tick();
        idle_in();
        for (int i = 0; i < 5; i++) tick();
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL flush_idle got=%b exp=0", bus.o_busy); end
        for (int i = 0; i < 40; i++) tick();
        read_hilo(F_MFHI, d);
        checks++; if (d !== 32'h0000AAAA) begin failures++; $display("FAIL flush_hi got=%h exp=0000aaaa", d); end
        read_hilo(F_MFLO, d);
        checks++; if (d !== 32'h00005555) begin failures++; $display("FAIL flush_lo got=%h exp=00005555", d); end
        drive(1'b1, CLS_RTYPE, F_MULT, 32'd2, 32'd3);
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        idle_in();
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL flush_issue_busy got=%b exp=0", bus.o_busy); end
        drive(1'b1, CLS_RTYPE, F_DIV, 32'd9, 32'd0);
        tick();
        idle_in();
        bus.i_flush = 1'b1;
        #1;
        checks++; if (bus.o_div_by_zero !== 1'b0) begin failures++; $display("FAIL flush_dbz got=%b exp=0", bus.o_div_by_zero); end
        tick();
        bus.i_flush = 1'b0;
        read_hilo(F_MFHI, d);
        checks++; if (d !== 32'h0000AAAA) begin failures++; $display("FAIL flush_dbz_hi got=%h exp=0000aaaa", d); end
        read_hilo(F_MFLO, d);
        checks++; if (d !== 32'h00005555) begin failures++; $display("FAIL flush_dbz_lo got=%h exp=00005555", d); end
        idle_in();
    endtask

    task automatic test_reset_mid();
        int n;
        logic [31:0] d;
        drive(1'b1, CLS_RTYPE, F_MULT, 32'd3, 32'd5);
        tick();
        idle_in();
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", bus.o_busy); end
        read_hilo(F_MFHI, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_mid_hi got=%h exp=00000000", d); end
        read_hilo(F_MFLO, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_mid_lo got=%h exp=00000000", d); end
        tick();
        rst_n = 1'b1;
        idle_in();
        tick();
        run_op(F_MULTU, 32'd6, 32'd7, n);
        checks++; if (n !== 33) begin failures++; $display("FAIL post_rst_busy_cycles got=%0d exp=33", n); end
        read_hilo(F_MFLO, d);
        checks++; if (d !== 32'd42) begin failures++; $display("FAIL post_rst_lo got=%h exp=0000002a", d); end
        idle_in();
    endtask

    initial begin
        bus.i_flush = 1'b0;
        idle_in();
        test_reset();
        test_decode();
        test_mult();
        test_div();
        test_div_by_zero();
        test_stall_mflo();
        test_mthi_stall();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
